// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I fetch path: fetch FSM states,
// the IF/ID register layout and the canonical bubble instruction.
package core_pkg;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_KILL,
    ST_HOLD
  } if_state_t;

  localparam logic [6:0]  OPC_STORE        = 7'b0100011;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  // A bubble carries pc 0 so a flushed slot never looks like a real fetch.
  function automatic if_id_t make_bubble(input logic [31:0] nop);
    return '{valid: 1'b0, pc: 32'h0, inst: nop};
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface if_id_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_id_stage_hold_buf.sv
// One-entry buffer that parks a fetched instruction while decode is stalled.
// Invalidate wins over load, which wins over drain.
module if_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        invalidate,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      inst  <= 32'h0;
    end else if (invalidate) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      inst  <= load_inst;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage with IF/ID pipeline register for the RV32I core.
// Optional feature macro: IF_PERF_CNT_EN adds saturating stall/flush counters.
module if_id_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ID_stall,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  if_id_stage_if.master        imem,
  output logic                 IF_ID_valid,
  output logic [31:0]          IF_ID_pc,
  output logic [31:0]          IF_ID_inst,
  output logic [4:0]           IF_ID_rs1,
  output logic [4:0]           IF_ID_rs2,
  output logic                 IF_ID_is_s_type
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  localparam if_id_t BUBBLE = make_bubble(NOP_INST);

  if_state_t   state, state_next;
  logic [31:0] pc, pc_next;
  if_id_t      if_id, if_id_next;

  logic        buf_load, buf_drain, buf_inval;
  logic        buf_valid;
  logic [31:0] buf_pc, buf_inst;
  logic [31:0] redirect_target;
  logic        outstanding;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // A response is still owed unless it is arriving in this very cycle.
  assign outstanding = ((state == ST_REQ) && imem.imem_ready) ||
                       ((state == ST_WAIT || state == ST_KILL) && !imem.imem_rvalid);

  if_hold_buf u_hold_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .drain      (buf_drain),
    .invalidate (buf_inval),
    .load_pc    (pc),
    .load_inst  (imem.imem_rdata),
    .valid      (buf_valid),
    .pc         (buf_pc),
    .inst       (buf_inst)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_REQ;
      pc    <= RESET_PC;
      if_id <= BUBBLE;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if_id <= if_id_next;
    end
  end

  // Decode consumes IF/ID every unstalled cycle, so it becomes a bubble unless
  // a new instruction is loaded; a stall freezes it.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    if_id_next     = ID_stall ? if_id : BUBBLE;
    buf_load       = 1'b0;
    buf_drain      = 1'b0;
    buf_inval      = 1'b0;
    imem.imem_req  = (state == ST_REQ);
    imem.imem_addr = pc;

    case (state)
      ST_REQ: begin
        if (imem.imem_ready) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem.imem_rvalid) begin
          if (!ID_stall) begin
            if_id_next = '{valid: 1'b1, pc: pc, inst: imem.imem_rdata};
            pc_next    = pc + 32'd4;
            state_next = ST_REQ;
          end else begin
            buf_load   = 1'b1;
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!buf_valid) begin
          state_next = ST_REQ;
        end else if (!ID_stall) begin
          if_id_next = '{valid: 1'b1, pc: buf_pc, inst: buf_inst};
          buf_drain  = 1'b1;
          pc_next    = pc + 32'd4;
          state_next = ST_REQ;
        end
      end
      ST_KILL: begin
        if (imem.imem_rvalid) state_next = ST_REQ;
      end
      default: state_next = ST_REQ;
    endcase

    // Redirect overrides everything above, including a stall.
    if (redirect_valid) begin
      if_id_next = BUBBLE;
      buf_load   = 1'b0;
      buf_drain  = 1'b0;
      buf_inval  = 1'b1;
      pc_next    = redirect_target;
      state_next = outstanding ? ST_KILL : ST_REQ;
    end
  end

  assign IF_ID_valid     = if_id.valid;
  assign IF_ID_pc        = if_id.pc;
  assign IF_ID_inst      = if_id.valid ? if_id.inst : NOP_INST;
  assign IF_ID_rs1       = if_id.valid ? if_id.inst[19:15] : 5'd0;
  assign IF_ID_rs2       = if_id.valid ? if_id.inst[24:20] : 5'd0;
  assign IF_ID_is_s_type = if_id.valid && (if_id.inst[6:0] == OPC_STORE);

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= 32'h0;
      perf_flush_cnt <= 32'h0;
    end else begin
      if (ID_stall && if_id.valid && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect_valid && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
